// File: rtl/pep_mmacc_body_rd_seq.sv
// Body read sequencer: issues boram reads with per-pid parity and turns
// the returned mod-switched bodies into rotation commands for mmacc.
module pep_mmacc_body_rd_seq #(
  parameter int PID_W        = 5,
  parameter int TOTAL_PBS_NB = 32,
  parameter int LWE_COEF_W   = 12,
  parameter int OUTST_DEPTH  = 4
) (
  input  logic                                   clk,
  input  logic                                   s_rst,
  input  logic [PID_W-1:0]                       cmd_pid,
  input  logic                                   cmd_vld,
  output logic                                   cmd_rdy,
  output logic [PID_W-1:0]                       boram_rd_pid,
  output logic                                   boram_rd_parity,
  output logic                                   boram_rd_vld,
  input  logic                                   boram_rd_rdy,
  input  logic [LWE_COEF_W-1:0]                  boram_sxt_data,
  input  logic                                   boram_sxt_data_vld,
  output logic                                   boram_sxt_data_rdy,
  output logic [PID_W-1:0]                       rot_pid,
  output logic [LWE_COEF_W-1:0]                  rot_factor,
  output logic                                   rot_vld,
  input  logic                                   rot_rdy,
  output logic [$clog2(OUTST_DEPTH+1)-1:0]       outst_cnt,
  output logic                                   err_unexp
);

  localparam int CNT_W = $clog2(OUTST_DEPTH + 1);
  localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;

  logic [TOTAL_PBS_NB-1:0] par;
  logic [PID_W-1:0]        fifo [OUTST_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;

  logic credit;
  logic empty;
  logic rd_hs;
  logic sxt_hs;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(OUTST_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit uses the registered count only; a same-cycle return frees nothing.
  assign credit = outst_cnt < CNT_W'(OUTST_DEPTH);
  assign empty  = outst_cnt == '0;

  assign boram_rd_vld    = cmd_vld & credit;
  assign boram_rd_pid    = cmd_pid;
  assign boram_rd_parity = par[cmd_pid];
  assign cmd_rdy         = boram_rd_rdy & credit;

  assign boram_sxt_data_rdy = ~rot_vld | rot_rdy;

  assign rd_hs  = boram_rd_vld & boram_rd_rdy;
  assign sxt_hs = boram_sxt_data_vld & boram_sxt_data_rdy;
  assign push   = rd_hs;
  assign pop    = sxt_hs & ~empty;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      par <= '0;
    end else if (rd_hs) begin
      par[cmd_pid] <= ~par[cmd_pid];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= cmd_pid;
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      outst_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   outst_cnt <= outst_cnt + 1'b1;
        2'b01:   outst_cnt <= outst_cnt - 1'b1;
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

  // Output register; a body arriving with nothing in flight is dropped.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      rot_vld    <= 1'b0;
      rot_pid    <= '0;
      rot_factor <= '0;
      err_unexp  <= 1'b0;
    end else begin
      if (pop) begin
        rot_vld    <= 1'b1;
        rot_pid    <= fifo[rd_ptr];
        rot_factor <= LWE_COEF_W'(0) - boram_sxt_data;
      end else if (rot_rdy) begin
        rot_vld    <= 1'b0;
      end
      if (sxt_hs & empty) begin
        err_unexp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pep_mmacc_body_rd_seq.sv
// Bench for pep_mmacc_body_rd_seq: directed cases plus a random stream
// checked cycle by cycle against a queue-based reference model.
module tb_pep_mmacc_body_rd_seq;

  localparam int PID_W = 5;
  localparam int NB    = 32;
  localparam int CW    = 12;
  localparam int OD    = 4;
  localparam int MOD   = 1 << CW;

  logic          clk = 1'b0;
  logic          s_rst;
  logic [PID_W-1:0] cmd_pid;
  logic          cmd_vld;
  logic          cmd_rdy;
  logic [PID_W-1:0] boram_rd_pid;
  logic          boram_rd_parity;
  logic          boram_rd_vld;
  logic          boram_rd_rdy;
  logic [CW-1:0] boram_sxt_data;
  logic          boram_sxt_data_vld;
  logic          boram_sxt_data_rdy;
  logic [PID_W-1:0] rot_pid;
  logic [CW-1:0] rot_factor;
  logic          rot_vld;
  logic          rot_rdy;
  logic [2:0]    outst_cnt;
  logic          err_unexp;

  always #5 clk = ~clk;

  pep_mmacc_body_rd_seq #(
    .PID_W(PID_W), .TOTAL_PBS_NB(NB),
    .LWE_COEF_W(CW), .OUTST_DEPTH(OD)
  ) dut (
    .clk(clk), .s_rst(s_rst),
    .cmd_pid(cmd_pid), .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy),
    .boram_rd_pid(boram_rd_pid),
    .boram_rd_parity(boram_rd_parity),
    .boram_rd_vld(boram_rd_vld),
    .boram_rd_rdy(boram_rd_rdy),
    .boram_sxt_data(boram_sxt_data),
    .boram_sxt_data_vld(boram_sxt_data_vld),
    .boram_sxt_data_rdy(boram_sxt_data_rdy),
    .rot_pid(rot_pid), .rot_factor(rot_factor),
    .rot_vld(rot_vld), .rot_rdy(rot_rdy),
    .outst_cnt(outst_cnt), .err_unexp(err_unexp)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model
  bit m_par [NB];
  int m_q [$];
  bit m_rv;
  int m_rpid;
  int m_rfac;
  bit m_err;
  int sb_pid [$];
  int sb_fac [$];
  int n_acc;
  int n_rot;

  task automatic m_reset();
    foreach (m_par[i]) m_par[i] = 1'b0;
    m_q.delete();
    sb_pid.delete();
    sb_fac.delete();
    m_rv = 0; m_rpid = 0; m_rfac = 0; m_err = 0;
  endtask

  task automatic cyc();
    bit credit, srdy, rd_hs, sxt_hs;
    int p, f;
    @(negedge clk);
    credit = m_q.size() < OD;
    srdy = !m_rv || rot_rdy;
    chk("cmd_rdy", cmd_rdy, boram_rd_rdy && credit);
    chk("rd_vld", boram_rd_vld, cmd_vld && credit);
    chk("rd_pid", boram_rd_pid, cmd_pid);
    chk("rd_parity", boram_rd_parity, m_par[cmd_pid]);
    chk("sxt_rdy", boram_sxt_data_rdy, srdy);
    chk("rot_vld", rot_vld, m_rv);
    chk("rot_pid", rot_pid, m_rpid);
    chk("rot_factor", rot_factor, m_rfac);
    chk("outst_cnt", outst_cnt, m_q.size());
    chk("err_unexp", err_unexp, m_err);
    if (rot_vld && rot_rdy && !s_rst) begin
      n_rot++;
      if (sb_pid.size() == 0 || sb_fac.size() == 0) begin
        chk("sb_extra_rot", 1, 0);
      end else begin
        p = sb_pid.pop_front();
        f = sb_fac.pop_front();
        chk("sb_order_pid", rot_pid, p);
        chk("sb_factor", rot_factor, f);
      end
    end
    rd_hs  = cmd_vld && boram_rd_rdy && credit;
    sxt_hs = boram_sxt_data_vld && srdy;
    @(posedge clk);
    if (s_rst) begin
      m_reset();
    end else begin
      if (sxt_hs) begin
        if (m_q.size() > 0) begin
          m_rpid = m_q.pop_front();
          m_rfac = (MOD - int'(boram_sxt_data)) % MOD;
          m_rv   = 1;
          sb_fac.push_back(m_rfac);
        end else begin
          m_err = 1;
        end
      end else if (m_rv && rot_rdy) begin
        m_rv = 0;
      end
      if (rd_hs) begin
        m_q.push_back(int'(cmd_pid));
        sb_pid.push_back(int'(cmd_pid));
        m_par[cmd_pid] = !m_par[cmd_pid];
        n_acc++;
      end
    end
    #1;
  endtask

  task automatic idle_in();
    cmd_vld = 0; cmd_pid = '0;
    boram_rd_rdy = 1; boram_sxt_data_vld = 0;
    boram_sxt_data = '0; rot_rdy = 1;
  endtask

  task automatic do_reset();
    idle_in();
    s_rst = 1;
    cyc(); cyc();
    s_rst = 0;
  endtask

  task automatic rnd_in(input bit allow_cmd);
    cmd_vld = allow_cmd && ($urandom % 4 != 0);
    cmd_pid = PID_W'($urandom % NB);
    boram_rd_rdy = ($urandom % 4 != 0);
    boram_sxt_data_vld = (m_q.size() > 0) && ($urandom % 2 == 1);
    boram_sxt_data = CW'($urandom);
    rot_rdy = ($urandom % 4 != 0);
  endtask

  task automatic drain();
    idle_in();
    for (int i = 0; i < 40 && (m_q.size() > 0 || m_rv); i++) begin
      boram_sxt_data_vld = m_q.size() > 0;
      boram_sxt_data = CW'($urandom);
      cyc();
    end
    idle_in();
  endtask

  initial begin
    int rot0;
    idle_in();
    s_rst = 1;
    m_reset();
    n_acc = 0; n_rot = 0;
    do_reset();
    #1;
    chk("rst_rot_vld", rot_vld, 0);
    chk("rst_outst", outst_cnt, 0);
    chk("rst_sxt_rdy", boram_sxt_data_rdy, 1);

    // Single fetch
    cmd_vld = 1; cmd_pid = 5'd3;
    #1 chk("single_par", boram_rd_parity, 0);
    cyc();
    idle_in(); cyc();
    boram_sxt_data_vld = 1; boram_sxt_data = 12'h005;
    cyc();
    idle_in();
    chk("single_vld", rot_vld, 1);
    chk("single_pid", rot_pid, 3);
    chk("single_fac", rot_factor, 12'hFFB);
    cyc();

    // Repeat pid
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cmd_vld = 1; cmd_pid = 5'd3;
      #1 chk("rep_par", boram_rd_parity, (i % 2 == 1));
      cyc();
    end
    cmd_vld = 0;
    #1 chk("rep_par_end", boram_rd_parity, 1);
    drain();

    // Credits
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cmd_vld = 1; cmd_pid = PID_W'($urandom % NB);
      cyc();
    end
    #1;
    chk("cred_cnt", outst_cnt, 4);
    chk("cred_rdy", cmd_rdy, 0);
    cmd_vld = 0;
    boram_sxt_data_vld = 1; boram_sxt_data = 12'h0AA;
    cyc();
    boram_sxt_data_vld = 0;
    #1 chk("cred_free", cmd_rdy, 1);
    drain();

    // Backpressure
    do_reset();
    cmd_vld = 1; cmd_pid = 5'd7; cyc();
    cmd_pid = 5'd9; cyc();
    cmd_vld = 0; rot_rdy = 0;
    boram_sxt_data_vld = 1; boram_sxt_data = 12'h000;
    cyc();
    chk("bp_vld", rot_vld, 1);
    chk("bp_fac0", rot_factor, 0);
    boram_sxt_data = 12'h800;
    #1 chk("bp_sxt_rdy", boram_sxt_data_rdy, 0);
    cyc(); cyc();
    chk("bp_hold_fac", rot_factor, 0);
    chk("bp_hold_pid", rot_pid, 7);
    rot_rdy = 1;
    cyc();
    boram_sxt_data_vld = 0;
    chk("bp_fac800", rot_factor, 12'h800);
    chk("bp_pid2", rot_pid, 9);
    drain();

    // Random stream
    do_reset();
    n_acc = 0; n_rot = 0;
    for (int c = 0; c < 20000; c++) begin
      if (n_acc >= 1000 && m_q.size() == 0 && !m_rv) break;
      rnd_in(n_acc < 1000);
      cyc();
    end
    idle_in();
    cyc();
    chk("stream_rot_cnt", n_rot, 1000);
    chk("stream_err", err_unexp, 0);

    // Unexpected body, then reset mid-traffic
    do_reset();
    boram_sxt_data_vld = 1; boram_sxt_data = 12'h123;
    rot0 = n_rot;
    cyc();
    idle_in();
    chk("unexp_err", err_unexp, 1);
    chk("unexp_no_rot", rot_vld, 0);
    cyc(); cyc(); cyc();
    chk("unexp_sticky", err_unexp, 1);
    chk("unexp_no_out", n_rot, rot0);
    for (int i = 0; i < 20; i++) begin
      rnd_in(1);
      cyc();
    end
    rnd_in(1);
    s_rst = 1;
    cyc();
    s_rst = 0;
    idle_in();
    boram_rd_rdy = 1;
    #1;
    chk("mrst_rot_vld", rot_vld, 0);
    chk("mrst_rot_pid", rot_pid, 0);
    chk("mrst_rot_fac", rot_factor, 0);
    chk("mrst_outst", outst_cnt, 0);
    chk("mrst_err", err_unexp, 0);
    chk("mrst_cmd_rdy", cmd_rdy, 1);
    chk("mrst_sxt_rdy", boram_sxt_data_rdy, 1);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
